// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states, status-flag
// bit positions (common with the multiplier) and the default operand width.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_S = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // A set top bit of rem_in means the true shifted value exceeds any divisor;
  // the modulo-2^(WIDTH+1) subtraction still yields the exact small result.
  assign shifted = {rem_in[WIDTH-1:0], dividend_bit};
  assign q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: one quotient bit per clock, results and
// status flags held from one completion to the next.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       status_flags
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_final;
  logic [3:0]       flags_run;
  logic [3:0]       flags_dz;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (dvd_q[WIDTH-1]),
    .divisor      (dvs_q),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  // Dividend register doubles as the quotient register as bits shift out.
  assign q_final = {dvd_q[WIDTH-2:0], q_bit};

  always_comb begin
    flags_run         = '0;
    flags_run[FLAG_Z] = (q_final == '0);
    flags_run[FLAG_S] = q_final[WIDTH-1];
    flags_run[FLAG_C] = (rem_next[WIDTH-1:0] != '0);
    flags_dz          = '0;
    flags_dz[FLAG_V]  = 1'b1;
    flags_dz[FLAG_S]  = 1'b1;
    flags_dz[FLAG_C]  = (a != '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (b == '0) ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      result       <= '0;
      remainder    <= '0;
      status_flags <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (b != '0)) begin
            dvd_q <= a;
            dvs_q <= b;
            rem_q <= '0;
            cnt_q <= CW'(WIDTH - 1);
          end else if (start) begin
            result       <= '1;
            remainder    <= a;
            status_flags <= flags_dz;
          end
        end
        RUN: begin
          dvd_q <= q_final;
          rem_q <= rem_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result       <= q_final;
            remainder    <= rem_next[WIDTH-1:0];
            status_flags <= flags_run;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: the driver queues expected quotient,
// remainder, flags and completion cycle; the monitor checks each done pulse.
module tb_div_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] result, remainder;
  logic [3:0] status_flags;

  div_seq #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .remainder    (remainder),
    .status_flags (status_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic [3:0]  f;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Reference: plain integer division, with the documented divide-by-zero result.
  function automatic exp_t model(input int unsigned x, input int unsigned y, input int unsigned c);
    exp_t e;
    int unsigned q, r;
    if (y == 0) begin
      e.q = 8'hFF;
      e.r = x[7:0];
      e.f = {1'b1, (x != 0), 1'b1, 1'b0};
      e.cyc = c + 1;
    end else begin
      q = x / y;
      r = x % y;
      e.q = q[7:0];
      e.r = r[7:0];
      e.f = {1'b0, (r != 0), (q >= 128), (q == 0)};
      e.cyc = c + 9;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("quotient", result, e.q);
        check("remainder", remainder, e.r);
        check("flags", status_flags, e.f);
      end
    end
  end

  task automatic issue(input int unsigned x, input int unsigned y, input bit expect_it);
    a = x[7:0];
    b = y[7:0];
    start = 1'b1;
    if (expect_it) sb.push_back(model(x, y, cyc));
  endtask

  task automatic wait_idle(output int unsigned n);
    int unsigned guard;
    n = 0;
    guard = 0;
    while (busy && guard < 30) begin
      n++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 30) check("idle_timeout", guard, 0);
  endtask

  task automatic run_op(input int unsigned x, input int unsigned y, output int unsigned nbusy);
    issue(x, y, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_idle(nbusy);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_flags"}, status_flags, 0);
  endtask

  initial begin
    int unsigned nb, seen0, guard;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    run_op(100, 7, nb);
    check("busy_cycles_normal", nb, 9);
    run_op(200, 1, nb);
    run_op(5, 9, nb);
    run_op(0, 3, nb);
    run_op(8'h2A, 0, nb);
    check("busy_cycles_div0", nb, 1);
    run_op(255, 255, nb);
    run_op(0, 0, nb);

    // Start pulse during RUN must be ignored.
    issue(255, 16, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    issue(9, 3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_idle(nb);

    // Reset mid-RUN aborts with no done pulse.
    issue(200, 7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    reset = 1'b0;
    start = 1'b0;
    seen0 = done_seen;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", done_seen, seen0);

    // Back-to-back sweep with start held high; each done must be 10 cycles apart.
    for (int i = 0; i < 1000; i++) begin
      issue($urandom_range(0, 255), $urandom_range(1, 255), 1'b1);
      if (i == 999) begin
        @(negedge clk);
        start = 1'b0;
      end else begin
        repeat (10) @(negedge clk);
      end
    end

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential 8-bit unsigned divider: the inverse operation of the combinational multiplier in the multiprocessor datapath's ALU bank. Accepts a dividend/divisor pair on a start pulse, runs a restoring shift-subtract loop one quotient bit per clock, then presents quotient, remainder and the same 4-bit status-flag layout used by the other arithmetic units. Sits beside the multiplier behind the operation mux. The control unit stalls on `busy` and captures results on `done`.

## Interface
- `WIDTH`, 8: operand, quotient and remainder width. Flags stay 4 bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  dividend, unsigned; latched when start is accepted.
- `b`  in  WIDTH  divisor, unsigned; latched when start is accepted.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; outputs are valid in this cycle.
- `result`  out  WIDTH  quotient.
- `remainder`  out  WIDTH  remainder.
- `status_flags`  out  4  [0] Z quotient==0, [1] S quotient MSB, [2] C remainder≠0, [3] V divide-by-zero.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - If `start`=1 and latched `b`≠0: load the dividend shift register with `a`, the partial remainder (WIDTH+1 bits) with 0 and the bit counter with WIDTH−1, then go to RUN.
  - If `start`=1 and `b`=0: go directly to DONE. Load `result`=all-ones, `remainder`=`a`, flags V=1, S=1, Z=0, C=(a≠0).
- **RUN**, each cycle:
  - Shift the dividend MSB into the partial remainder LSB: r' = {r, a_msb}.
  - If r' ≥ divisor: r = r' − divisor and shift quotient bit 1 in. Otherwise r = r' and shift 0 in.
  - Decrement the counter. On the cycle the counter is 0, register `result`, `remainder` and `status_flags`, then go to DONE.
- **DONE**: `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE. No queuing.
- `result`, `remainder` and `status_flags` hold their values from the last completion until the next completion. They do not change during RUN.
- Width rule: the partial remainder is WIDTH+1 bits internally, so the comparison never overflows. The final remainder is always < divisor and fits in WIDTH bits.
- Reset mid-operation: aborts at once. Next state is IDLE and all outputs return to their reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `remainder`=0, `status_flags`=0. State is IDLE.
- Normal latency: start sampled at edge k. Iterations run at edges k+1…k+WIDTH. `done` is high in the cycle following edge k+WIDTH (8 cycles after start for WIDTH=8). Back in IDLE after edge k+WIDTH+1.
- Divide-by-zero latency: `done` is high in the cycle following edge k.
- `busy` rises in the cycle after the start edge and stays high through the DONE cycle.
- Minimum start-to-start spacing: WIDTH+2 cycles. A start held high continuously re-launches on the first IDLE cycle.
- Simultaneous `reset` and `start`: reset wins.

## Structure
- Package `div_pkg` holds:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - flag bit index constants FLAG_Z=0, FLAG_S=1, FLAG_C=2, FLAG_V=3, shared with the multiplier
  - DIV_WIDTH default 8
- One sub-module, `div_step`: combinational single restoring iteration. Inputs are partial remainder, incoming dividend bit and divisor. Outputs are the new partial remainder and the quotient bit. Instantiated once in `div_seq`.
- Counter width is $clog2(WIDTH).

## Test plan
- a=100, b=7, start 1 cycle → after 8 cycles `done`=1: result=14, remainder=2, flags=4'b0100. `busy` is high for 9 cycles.
- a=200, b=1 → result=0xC8, remainder=0, flags=4'b0010.
- a=5, b=9 → result=0, remainder=5, flags=4'b0101. Then a=0, b=3 → result=0, remainder=0, flags=4'b0001.
- a=0x2A, b=0 → `done` 1 cycle after start: result=0xFF, remainder=0x2A, flags=4'b1110.
- a=255, b=16 in flight; pulse start with a=9, b=3 at cycle 3 → ignored. Result=15, remainder=15. Then assert reset during a new RUN at cycle 4 → next cycle all outputs are 0, `busy`=0, and no `done` pulse occurs.
- Random sweep of 1000 (a, b) pairs with b≠0, back-to-back starts held high → every `done` matches a/b and a%b. Spacing is exactly 10 cycles.
